// File: rtl/ddr_cmd_decoder_pkg.sv
// Shared types and constants for the DDR command decoder.
// Optional timing checks are enabled with DDR_DEC_TIMING_CHK_EN.
package ddr_pkg;

    localparam int NBANK = 4;
    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 10;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_LMR = 3'd6,
        CMD_BST = 3'd7
    } cmd_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
    localparam logic [2:0] ERR_RW_IDLE  = 3'd2;
    localparam logic [2:0] ERR_TRCD     = 3'd3;
    localparam logic [2:0] ERR_TRP      = 3'd4;
    localparam logic [2:0] ERR_REF_OPEN = 3'd5;

    function automatic cmd_e decode(input logic ras, input logic cas,
                                    input logic we);
        cmd_e c;
        unique case ({ras, cas, we})
            3'b011:  c = CMD_ACT;
            3'b101:  c = CMD_RD;
            3'b100:  c = CMD_WR;
            3'b010:  c = CMD_PRE;
            3'b001:  c = CMD_REF;
            3'b000:  c = CMD_LMR;
            3'b110:  c = CMD_BST;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ddr_cmd_decoder_if.sv
// DDR command bus in, decoded command and status out.
interface ddr_cmd_decoder_if;
    import ddr_pkg::*;

    logic             cke;
    logic             ras;
    logic             cas;
    logic             we;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] addr;

    cmd_e             cmd;
    logic             cmd_valid;
    logic [BA_W-1:0]  cmd_ba;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic [NBANK-1:0] bank_open;
    logic             err;
    logic [2:0]       err_code;

    modport master (
        output cke, ras, cas, we, ba, addr,
        input  cmd, cmd_valid, cmd_ba, cmd_row, cmd_col,
        input  bank_open, err, err_code
    );

    modport slave (
        input  cke, ras, cas, we, ba, addr,
        output cmd, cmd_valid, cmd_ba, cmd_row, cmd_col,
        output bank_open, err, err_code
    );

endinterface

// File: rtl/ddr_bank_tracker.sv
// One bank: open/idle state, open row and (with DDR_DEC_TIMING_CHK_EN)
// the tRCD/tRP down-counters.
module ddr_bank_tracker
    import ddr_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_act,
    input  logic             i_pre,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_open,
    output logic [ROW_W-1:0] o_row,
    output logic             o_rcd_busy,
    output logic             o_rp_busy
);

    logic             r_open;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_open <= 1'b0;
            r_row  <= '0;
        end else if (i_act) begin
            r_open <= 1'b1;
            r_row  <= i_row;
        end else if (i_pre) begin
            r_open <= 1'b0;
        end
    end

    assign o_open = r_open;
    assign o_row  = r_row;

`ifdef DDR_DEC_TIMING_CHK_EN
    logic [1:0] r_rcd;
    logic [1:0] r_rp;

    // A load wins over the per-cycle decrement; both saturate at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcd <= '0;
            r_rp  <= '0;
        end else begin
            if (i_act)
                r_rcd <= 2'(T_RCD - 1);
            else if (r_rcd != 2'd0)
                r_rcd <= r_rcd - 2'd1;
            if (i_pre)
                r_rp <= 2'(T_RP - 1);
            else if (r_rp != 2'd0)
                r_rp <= r_rp - 2'd1;
        end
    end

    assign o_rcd_busy = (r_rcd != 2'd0);
    assign o_rp_busy  = (r_rp != 2'd0);
`else
    assign o_rcd_busy = 1'b0;
    assign o_rp_busy  = 1'b0;
`endif

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR command decoder: decode, error priority, bank tracking, output regs.
// Define DDR_DEC_TIMING_CHK_EN to enable tRCD/tRP checks (codes 3, 4).
module ddr_cmd_decoder
    import ddr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    ddr_cmd_decoder_if.slave bus
);

    cmd_e             w_cmd;
    logic [BA_W-1:0]  w_ba;
    logic [NBANK-1:0] w_open;
    logic [NBANK-1:0] w_rcd_busy;
    logic [NBANK-1:0] w_rp_busy;
    logic [NBANK-1:0] w_act;
    logic [NBANK-1:0] w_pre;
    logic [ROW_W-1:0] w_row [NBANK];
    logic [2:0]       w_code;
    logic             w_rw;

    assign w_cmd = bus.cke ? decode(bus.ras, bus.cas, bus.we) : CMD_NOP;
    assign w_ba  = bus.ba;
    assign w_rw  = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);

    always_comb begin
        w_code = ERR_NONE;
        if (w_cmd == CMD_ACT && w_open[w_ba])
            w_code = ERR_ACT_OPEN;
        else if (w_rw && !w_open[w_ba])
            w_code = ERR_RW_IDLE;
        else if ((w_cmd == CMD_REF || w_cmd == CMD_LMR) && |w_open)
            w_code = ERR_REF_OPEN;
        else if (w_rw && w_rcd_busy[w_ba])
            w_code = ERR_TRCD;
        else if (w_cmd == CMD_ACT && w_rp_busy[w_ba])
            w_code = ERR_TRP;
    end

    // Flagged commands leave bank state and counters untouched.
    always_comb begin
        w_act = '0;
        w_pre = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (w_code == ERR_NONE) begin
                w_act[b] = (w_cmd == CMD_ACT) && (w_ba == BA_W'(b));
                w_pre[b] = (w_cmd == CMD_PRE) &&
                           (bus.addr[10] || w_ba == BA_W'(b));
            end
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        ddr_bank_tracker u_bank (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_act      (w_act[g]),
            .i_pre      (w_pre[g]),
            .i_row      (bus.addr),
            .o_open     (w_open[g]),
            .o_row      (w_row[g]),
            .o_rcd_busy (w_rcd_busy[g]),
            .o_rp_busy  (w_rp_busy[g])
        );
    end

    cmd_e             r_cmd;
    logic             r_valid;
    logic [BA_W-1:0]  r_ba;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_err;
    logic [2:0]       r_code;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd   <= CMD_NOP;
            r_valid <= 1'b0;
            r_ba    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_cmd   <= w_cmd;
            r_valid <= (w_cmd != CMD_NOP);
            r_ba    <= (w_cmd != CMD_NOP) ? w_ba : '0;
            r_row   <= (w_cmd == CMD_ACT) ? bus.addr :
                       w_rw ? w_row[w_ba] : '0;
            r_col   <= w_rw ? bus.addr[COL_W-1:0] : '0;
            r_err   <= (w_code != ERR_NONE);
            r_code  <= w_code;
        end
    end

    assign bus.cmd       = r_cmd;
    assign bus.cmd_valid = r_valid;
    assign bus.cmd_ba    = r_ba;
    assign bus.cmd_row   = r_row;
    assign bus.cmd_col   = r_col;
    assign bus.err       = r_err;
    assign bus.err_code  = r_code;
    assign bus.bank_open = w_open;

endmodule
